digit_seq_ctrl: RTL and testbench
=================================

DIGIT_SEQ_CTRL -- requirements
Module: digit_seq_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 6, giving the sequence table depth (2..8).
REQ-002 The block SHALL have parameter DWELL_DEF, default 10, giving the dwell reload value after reset (1..15).
REQ-003 clk  in  1  the single clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 count_up  in  1  dwell tick enable, sampled on every clk edge.
REQ-006 start  in  1  one-cycle command that begins or resumes sequencing.
REQ-007 stop  in  1  one-cycle command that halts sequencing and returns to IDLE.
REQ-008 step  in  1  one-cycle command that advances one digit while in HOLD.
REQ-009 wr_en / wr_addr / wr_data  in  1/3/4  table entry write port.
REQ-010 dwell_wr / dwell_in  in  1/4  dwell register load strobe and value.
REQ-011 y  out  4  displayed hex code.
REQ-012 digit_idx  out  3  index of the current table entry.
REQ-013 busy  out  1  high in RUN and HOLD.
REQ-014 wrap  out  1  one-cycle pulse when digit_idx wraps from NUM_DIGITS-1 to 0.

Function
REQ-015 The FSM SHALL have exactly these states: IDLE, RUN and HOLD.
REQ-016 IDLE transitions: start goes to RUN with digit_idx=0 and the tick count at 0.
REQ-017 RUN transitions: stop goes to IDLE; start while already in RUN goes to HOLD (pause toggle).
REQ-018 HOLD transitions: start goes to RUN without clearing the tick count; step advances one digit and stays in HOLD; stop goes to IDLE.
REQ-019 In RUN, each cycle with count_up=1 SHALL increment the tick count; when the count reaches dwell-1 on a tick, digit_idx SHALL advance and the count SHALL clear, so each digit is held exactly dwell ticks.
REQ-020 A dwell value of 0 SHALL be treated as 1.
REQ-021 count_up SHALL be ignored outside RUN.
REQ-022 Advance from NUM_DIGITS-1 SHALL wrap digit_idx to 0 and assert wrap for that one cycle only.
REQ-023 y SHALL be registered and SHALL equal table[digit_idx] updated on the same edge as digit_idx (zero extra latency).
REQ-024 Priority for simultaneous commands SHALL be stop > start > step.
REQ-025 Table writes SHALL be accepted in any state.
REQ-026 A table write with wr_addr >= NUM_DIGITS SHALL be ignored.
REQ-027 A table write to the current entry SHALL appear on y on the next edge.
REQ-028 dwell_wr SHALL take effect at the next digit boundary and SHALL NOT truncate the digit currently on display.

Reset
REQ-029 While reset=0, the block SHALL be in state IDLE with digit_idx=0, tick count=0, dwell=DWELL_DEF, busy=0 and wrap=0.
REQ-030 Reset SHALL load the table with C,0,E,3,1,2 (entries beyond 6 = 0) and set y=4'hC.
REQ-031 Assertion of reset mid-sequence SHALL abort immediately and asynchronously.
REQ-032 After reset is released, the block SHALL remain in IDLE until start.

Configuration
REQ-033 With DIGIT_SEQ_BLANK_EN defined, y SHALL be 4'hF (blank) whenever the state is IDLE, including out of reset.
REQ-034 With DIGIT_SEQ_BLANK_EN undefined, y in IDLE SHALL show table[digit_idx] as in REQ-023.

Structure
REQ-035 Package digit_seq_pkg SHALL hold the state encoding, the reset digit table constants and the BLANK code 4'hF.
REQ-036 The tick count, dwell register and boundary compare SHALL be one sub-module, seq_dwell_timer, which outputs a one-cycle advance pulse.

Verification
REQ-037 Reset, start, count_up held high with default dwell: y SHALL step C,0,E,3,1,2,C, each held 10 cycles, with wrap pulsing on the 2->C edge.
REQ-038 Start, 4 ticks, start (pause), 5 cycles of count_up, start: the current digit SHALL hold for exactly 6 more ticks, for 10 ticks total.
REQ-039 In HOLD with step and start high together: the block SHALL resume RUN and digit_idx SHALL be unchanged.
REQ-040 Write wr_addr=1, wr_data=4'h7 while digit 1 is displayed: y SHALL be 7 next cycle; a write with wr_addr=6 SHALL be ignored.
REQ-041 dwell_in=3 loaded mid-digit: the current digit SHALL finish its 10 ticks and the following digits SHALL last 3 ticks; dwell_in=0 SHALL give 1 tick per digit.
REQ-042 Reset asserted mid-RUN on digit E: y SHALL return to C (or F with DIGIT_SEQ_BLANK_EN) and busy to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/digit_seq_pkg.sv
// rtl/digit_seq_pkg.sv - state encoding, reset digit table and blank code for digit_seq_ctrl
package digit_seq_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam logic [3:0] BLANK = 4'hF;

    localparam logic [3:0] RESET_DIGIT_0 = 4'hC;
    localparam logic [3:0] RESET_DIGIT_1 = 4'h0;
    localparam logic [3:0] RESET_DIGIT_2 = 4'hE;
    localparam logic [3:0] RESET_DIGIT_3 = 4'h3;
    localparam logic [3:0] RESET_DIGIT_4 = 4'h1;
    localparam logic [3:0] RESET_DIGIT_5 = 4'h2;

    function automatic logic [3:0] reset_digit(input int unsigned i);
        case (i)
            0:       reset_digit = RESET_DIGIT_0;
            1:       reset_digit = RESET_DIGIT_1;
            2:       reset_digit = RESET_DIGIT_2;
            3:       reset_digit = RESET_DIGIT_3;
            4:       reset_digit = RESET_DIGIT_4;
            5:       reset_digit = RESET_DIGIT_5;
            default: reset_digit = 4'h0;
        endcase
    endfunction

endpackage

// File: rtl/seq_dwell_timer.sv
// rtl/seq_dwell_timer.sv - dwell tick counter with deferred dwell reload and one-cycle advance pulse
module seq_dwell_timer #(
    parameter int DWELL_DEF = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       clear,
    input  logic       load,
    input  logic       dwell_wr,
    input  logic [3:0] dwell_in,
    output logic       adv
);

    logic [3:0] count;
    logic [3:0] dwell_pend;
    logic [3:0] dwell_act;
    logic [3:0] dwell_next;
    logic [3:0] last_count;

    // A new dwell waits in dwell_pend until a digit boundary so the shown digit keeps its length.
    assign dwell_next = dwell_wr ? dwell_in : dwell_pend;
    assign last_count = (dwell_act == 4'd0) ? 4'd0 : dwell_act - 4'd1;
    assign adv        = tick && (count == last_count);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count      <= '0;
            dwell_pend <= 4'(DWELL_DEF);
            dwell_act  <= 4'(DWELL_DEF);
        end else begin
            dwell_pend <= dwell_next;
            if (load || adv) begin
                dwell_act <= dwell_next;
            end
            if (clear || adv) begin
                count <= '0;
            end else if (tick) begin
                count <= count + 4'd1;
            end
        end
    end

endmodule

// File: rtl/digit_seq_ctrl.sv
// rtl/digit_seq_ctrl.sv - digit sequencer: IDLE/RUN/HOLD FSM, digit table, registered display code
// Optional: DIGIT_SEQ_BLANK_EN shows the blank code on y whenever the FSM is IDLE.
module digit_seq_ctrl #(
    parameter int NUM_DIGITS = 6,
    parameter int DWELL_DEF  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       count_up,
    input  logic       start,
    input  logic       stop,
    input  logic       step,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [3:0] wr_data,
    input  logic       dwell_wr,
    input  logic [3:0] dwell_in,
    output logic [3:0] y,
    output logic [2:0] digit_idx,
    output logic       busy,
    output logic       wrap
);

    import digit_seq_pkg::*;

    localparam logic [2:0] LAST_IDX = 3'(NUM_DIGITS - 1);

    logic [1:0] state;
    logic [1:0] state_next;
    logic [2:0] idx_next;
    logic [3:0] tbl [NUM_DIGITS];
    logic       advance;
    logic       wrap_next;
    logic       tick_en;
    logic       tmr_clear;
    logic       tmr_load;
    logic       adv_pulse;
    logic       wr_valid;
    logic       wr_hit;
    logic [3:0] y_next;

    assign wr_valid = wr_en && (32'(wr_addr) < 32'(NUM_DIGITS));
    // Any command on a RUN cycle owns that cycle; the tick is not counted.
    assign tick_en  = (state == ST_RUN) && !stop && !start && count_up;
    assign tmr_load = tmr_clear || (state == ST_IDLE);
    assign busy     = (state != ST_IDLE);

    seq_dwell_timer #(
        .DWELL_DEF (DWELL_DEF)
    ) u_timer (
        .clk      (clk),
        .rst_n    (reset),
        .tick     (tick_en),
        .clear    (tmr_clear),
        .load     (tmr_load),
        .dwell_wr (dwell_wr),
        .dwell_in (dwell_in),
        .adv      (adv_pulse)
    );

    always_comb begin
        state_next = state;
        advance    = 1'b0;
        tmr_clear  = 1'b0;
        case (state)
            ST_IDLE: begin
                tmr_clear = 1'b1;
                if (!stop && start) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_next = ST_IDLE;
                    tmr_clear  = 1'b1;
                end else if (start) begin
                    state_next = ST_HOLD;
                end else if (adv_pulse) begin
                    advance = 1'b1;
                end
            end
            ST_HOLD: begin
                if (stop) begin
                    state_next = ST_IDLE;
                    tmr_clear  = 1'b1;
                end else if (start) begin
                    state_next = ST_RUN;
                end else if (step) begin
                    advance   = 1'b1;
                    tmr_clear = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                tmr_clear  = 1'b1;
            end
        endcase
    end

    always_comb begin
        wrap_next = advance && (digit_idx == LAST_IDX);
        idx_next  = digit_idx;
        if ((state == ST_IDLE) && !stop && start) begin
            idx_next = '0;
        end else if (advance) begin
            idx_next = wrap_next ? 3'd0 : digit_idx + 3'd1;
        end
    end

    // y is computed from next-state values so it moves on the same edge as digit_idx.
    always_comb begin
        wr_hit = wr_valid && (wr_addr == idx_next);
        y_next = wr_hit ? wr_data : tbl[idx_next];
`ifdef DIGIT_SEQ_BLANK_EN
        if (state_next == ST_IDLE) begin
            y_next = BLANK;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            digit_idx <= '0;
            wrap      <= 1'b0;
`ifdef DIGIT_SEQ_BLANK_EN
            y         <= BLANK;
`else
            y         <= reset_digit(0);
`endif
        end else begin
            state     <= state_next;
            digit_idx <= idx_next;
            wrap      <= wrap_next;
            y         <= y_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                tbl[i] <= reset_digit(i);
            end
        end else if (wr_valid) begin
            tbl[wr_addr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_digit_seq_ctrl.sv
// tb/tb_digit_seq_ctrl.sv - self-checking bench for digit_seq_ctrl with directed and random stimulus
module tb_digit_seq_ctrl;

    localparam int ND = 6;
    localparam int DW = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic       count_up, start, stop, step, wr_en, dwell_wr;
    logic [2:0] wr_addr;
    logic [3:0] wr_data, dwell_in;
    logic [3:0] y;
    logic [2:0] digit_idx;
    logic       busy, wrap;

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    // reference model: mode 0=idle 1=run 2=hold
    int         m_mode, m_idx, m_ticks, m_cur, m_pend;
    bit         m_wrap;
    logic [3:0] m_tab [8];
    logic [3:0] seq [7];

    digit_seq_ctrl #(.NUM_DIGITS(ND), .DWELL_DEF(DW)) dut (
        .clk(clk), .reset(reset), .count_up(count_up), .start(start), .stop(stop),
        .step(step), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .dwell_wr(dwell_wr), .dwell_in(dwell_in), .y(y), .digit_idx(digit_idx),
        .busy(busy), .wrap(wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_idx = 0; m_ticks = 0; m_cur = DW; m_pend = DW; m_wrap = 0;
        m_tab[0] = 4'hC; m_tab[1] = 4'h0; m_tab[2] = 4'hE; m_tab[3] = 4'h3;
        m_tab[4] = 4'h1; m_tab[5] = 4'h2; m_tab[6] = 4'h0; m_tab[7] = 4'h0;
    endtask

    function automatic logic [3:0] exp_y();
`ifdef DIGIT_SEQ_BLANK_EN
        if (m_mode == 0) return 4'hF;
`endif
        return m_tab[m_idx];
    endfunction

    task automatic m_advance();
        if (m_idx == ND - 1) begin m_idx = 0; m_wrap = 1; end
        else m_idx++;
    endtask

    task automatic model_step();
        bit was_idle = (m_mode == 0);
        bit bnd = 0;
        m_wrap = 0;
        if (dwell_wr) m_pend = int'(dwell_in);
        if (stop) begin
            m_mode = 0; m_ticks = 0; bnd = 1;
        end else if (start) begin
            if (m_mode == 0) begin m_mode = 1; m_idx = 0; m_ticks = 0; end
            else if (m_mode == 1) m_mode = 2;
            else m_mode = 1;
        end else if (step && m_mode == 2) begin
            m_advance(); m_ticks = 0; bnd = 1;
        end else if (count_up && m_mode == 1) begin
            m_ticks++;
            if (m_ticks >= ((m_cur == 0) ? 1 : m_cur)) begin
                m_advance(); m_ticks = 0; bnd = 1;
            end
        end
        if (bnd || was_idle) m_cur = m_pend;
        if (wr_en && int'(wr_addr) < ND) m_tab[wr_addr] = wr_data;
    endtask

    task automatic do_cycle(input bit st, input bit sp, input bit stp, input bit cu,
                            input bit we, input logic [2:0] wa, input logic [3:0] wd,
                            input bit dw, input logic [3:0] din);
        start = st; stop = sp; step = stp; count_up = cu;
        wr_en = we; wr_addr = wa; wr_data = wd; dwell_wr = dw; dwell_in = din;
        model_step();
        @(posedge clk);
        #1;
        check("y", 8'(y), 8'(exp_y()));
        check("digit_idx", 8'(digit_idx), 8'(m_idx));
        check("busy", 8'(busy), 8'(m_mode != 0));
        check("wrap", 8'(wrap), 8'(m_wrap));
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) do_cycle(0, 0, 0, 1, 0, 0, 0, 0, 0);
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        @(posedge clk); #1;
        model_reset();
`ifdef DIGIT_SEQ_BLANK_EN
        check("rst_y", 8'(y), 8'hF);
`else
        check("rst_y", 8'(y), 8'hC);
`endif
        check("rst_idx", 8'(digit_idx), 8'd0);
        check("rst_busy", 8'(busy), 8'd0);
        check("rst_wrap", 8'(wrap), 8'd0);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0; count_up = 0; start = 0; stop = 0; step = 0;
        wr_en = 0; wr_addr = 0; wr_data = 0; dwell_wr = 0; dwell_in = 0;
        seq[0] = 4'hC; seq[1] = 4'h0; seq[2] = 4'hE; seq[3] = 4'h3;
        seq[4] = 4'h1; seq[5] = 4'h2; seq[6] = 4'hC;
        @(posedge clk);
        apply_reset();

        // stays idle after reset release, even with ticks
        tick_n(3);
        check("idle_hold_busy", 8'(busy), 8'd0);

        // full sequence with default dwell
        do_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        check("seq_start_y", 8'(y), 8'hC);
        for (int k = 1; k <= 60; k++) begin
            do_cycle(0, 0, 0, 1, 0, 0, 0, 0, 0);
            check("seq_y", 8'(y), 8'(seq[k / 10]));
            check("seq_wrap", 8'(wrap), 8'(k == 60));
        end

        // pause keeps the tick count
        do_cycle(0, 1, 0, 0, 0, 0, 0, 0, 0);
        do_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick_n(4);
        do_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick_n(5);
        check("pause_idx", 8'(digit_idx), 8'd0);
        check("pause_busy", 8'(busy), 8'd1);
        do_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick_n(5);
        check("resume5_idx", 8'(digit_idx), 8'd0);
        tick_n(1);
        check("resume6_idx", 8'(digit_idx), 8'd1);

        // step in hold, then step+start resumes without stepping
        do_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        do_cycle(0, 0, 1, 0, 0, 0, 0, 0, 0);
        check("step_idx", 8'(digit_idx), 8'd2);
        do_cycle(1, 0, 1, 0, 0, 0, 0, 0, 0);
        check("stepstart_idx", 8'(digit_idx), 8'd2);
        tick_n(10);
        check("stepstart_run_idx", 8'(digit_idx), 8'd3);

        // table writes
        do_cycle(0, 1, 0, 0, 0, 0, 0, 0, 0);
        do_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick_n(10);
        check("wr_pre_y", 8'(y), 8'h0);
        do_cycle(0, 0, 0, 0, 1, 3'd1, 4'h7, 0, 0);
        check("wr_cur_y", 8'(y), 8'h7);
        do_cycle(0, 0, 0, 0, 1, 3'd6, 4'h5, 0, 0);
        check("wr_oob_y", 8'(y), 8'h7);

        // deferred dwell reload
        do_cycle(0, 1, 0, 0, 0, 0, 0, 0, 0);
        do_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick_n(4);
        do_cycle(0, 0, 0, 0, 0, 0, 0, 1, 4'd3);
        tick_n(5);
        check("dw_old_idx", 8'(digit_idx), 8'd0);
        tick_n(1);
        check("dw_bnd_idx", 8'(digit_idx), 8'd1);
        tick_n(2);
        check("dw3_mid_idx", 8'(digit_idx), 8'd1);
        tick_n(1);
        check("dw3_end_idx", 8'(digit_idx), 8'd2);
        do_cycle(0, 0, 0, 0, 0, 0, 0, 1, 4'd0);
        tick_n(3);
        check("dw0_pre_idx", 8'(digit_idx), 8'd3);
        tick_n(1);
        check("dw0_a_idx", 8'(digit_idx), 8'd4);
        tick_n(1);
        check("dw0_b_idx", 8'(digit_idx), 8'd5);

        // random traffic against the model
        for (int n = 0; n < 1500; n++) begin
            do_cycle(($urandom_range(0, 15) == 0), ($urandom_range(0, 39) == 0),
                     ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) < 7),
                     ($urandom_range(0, 7) == 0), 3'($urandom_range(0, 7)),
                     4'($urandom_range(0, 15)), ($urandom_range(0, 29) == 0),
                     4'($urandom_range(0, 4)));
        end

        // asynchronous reset mid-run on digit E
        apply_reset();
        do_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick_n(20);
        check("pre_async_y", 8'(y), 8'hE);
        #3;
        reset = 1'b0;
        #1;
`ifdef DIGIT_SEQ_BLANK_EN
        check("async_y", 8'(y), 8'hF);
`else
        check("async_y", 8'(y), 8'hC);
`endif
        check("async_busy", 8'(busy), 8'd0);
        check("async_idx", 8'(digit_idx), 8'd0);
        @(posedge clk); #1;
        reset = 1'b1;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
